// File: rtl/fpu_issue_ctrl.sv
// fpu_issue_ctrl: single-issue sequencer that drives a registered command into a combinational
// FPU, waits RESULT_LAT cycles, then returns result and flags. Option macro: FPU_NANBOX_EN.
module fpu_issue_ctrl #(
  parameter int unsigned RESULT_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [6:0]  req_func7,
  input  logic [2:0]  req_func3,
  input  logic [4:0]  req_rs2,
  input  logic [4:0]  req_rd,
  input  logic [63:0] req_a,
  input  logic [63:0] req_b,
  input  logic [2:0]  fcsr_frm,
  output logic [6:0]  fpu_func7,
  output logic [2:0]  fpu_func3,
  output logic [4:0]  fpu_rs2,
  output logic [63:0] fpu_operand_a,
  output logic [63:0] fpu_operand_b,
  input  logic [63:0] fpu_result,
  input  logic        fpu_flag_invalid,
  input  logic        fpu_flag_divbyzero,
  input  logic        fpu_flag_overflow,
  input  logic        fpu_flag_underflow,
  input  logic        fpu_flag_inexact,
  input  logic        fpu_flag_cmp,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [4:0]  rsp_rd,
  output logic [63:0] rsp_data,
  output logic [4:0]  rsp_fflags,
  output logic        rsp_illegal,
  output logic [4:0]  fflags,
  input  logic        fflags_clr,
  output logic        busy
);

  localparam logic [6:0] F_CMP_S = 7'h50;
  localparam logic [6:0] F_CMP_D = 7'h51;
  localparam logic [3:0] LAT     = 4'(RESULT_LAT);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  function automatic logic op_supported(input logic [6:0] f7);
    case (f7)
      7'h00, 7'h04, 7'h01, 7'h05, 7'h50, 7'h51,
      7'h21, 7'h60, 7'h69, 7'h20, 7'h61, 7'h68: return 1'b1;
      default:                                  return 1'b0;
    endcase
  endfunction

`ifdef FPU_NANBOX_EN
  function automatic logic single_result(input logic [6:0] f7);
    case (f7)
      7'h00, 7'h04, 7'h20, 7'h68: return 1'b1;
      default:                    return 1'b0;
    endcase
  endfunction
`endif

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [6:0]  fpu_func7_q, fpu_func7_d;
  logic [2:0]  fpu_func3_q, fpu_func3_d;
  logic [4:0]  fpu_rs2_q, fpu_rs2_d;
  logic [63:0] fpu_a_q, fpu_a_d;
  logic [63:0] fpu_b_q, fpu_b_d;
  logic [4:0]  rsp_rd_q, rsp_rd_d;
  logic [63:0] rsp_data_q, rsp_data_d;
  logic [4:0]  rsp_fflags_q, rsp_fflags_d;
  logic        rsp_illegal_q, rsp_illegal_d;
  logic [4:0]  fflags_q, fflags_d;

  logic        req_is_cmp;
  logic [2:0]  req_rm;
  logic        req_legal;
  logic [63:0] cap_data;
  logic        handshake;

  always_comb begin
    // NOTE: every _d defaults to its _q first, so no branch below can leave one unassigned and infer a latch.
    state_d       = state_q;
    cnt_d         = cnt_q;
    fpu_func7_d   = fpu_func7_q;
    fpu_func3_d   = fpu_func3_q;
    fpu_rs2_d     = fpu_rs2_q;
    fpu_a_d       = fpu_a_q;
    fpu_b_d       = fpu_b_q;
    rsp_rd_d      = rsp_rd_q;
    rsp_data_d    = rsp_data_q;
    rsp_fflags_d  = rsp_fflags_q;
    rsp_illegal_d = rsp_illegal_q;
    fflags_d      = fflags_q;

    // Compare ops use func3 as the predicate select, so it is neither resolved nor range-checked.
    req_is_cmp = (req_func7 == F_CMP_S) || (req_func7 == F_CMP_D);
    req_rm     = (!req_is_cmp && req_func3 == 3'b111) ? fcsr_frm : req_func3;
    req_legal  = op_supported(req_func7) && (req_is_cmp || req_rm < 3'd5);

    if (fpu_func7_q == F_CMP_S || fpu_func7_q == F_CMP_D) begin
      cap_data = {63'b0, fpu_flag_cmp};
    end else begin
      cap_data = fpu_result;
`ifdef FPU_NANBOX_EN
      if (single_result(fpu_func7_q)) cap_data[63:32] = 32'hFFFF_FFFF;
`endif
    end

    handshake = (state_q == RESP) && rsp_ready;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          rsp_rd_d = req_rd;
          if (req_legal) begin
            fpu_func7_d = req_func7;
            fpu_func3_d = req_rm;
            fpu_rs2_d   = req_rs2;
            fpu_a_d     = req_a;
            fpu_b_d     = req_b;
            cnt_d       = LAT;
            state_d     = EXEC;
          end else begin
            rsp_illegal_d = 1'b1;
            rsp_data_d    = 64'b0;
            rsp_fflags_d  = 5'b0;
            state_d       = RESP;
          end
        end
      end
      EXEC: begin
        if (cnt_q == 4'd1) begin
          rsp_data_d    = cap_data;
          rsp_fflags_d  = {fpu_flag_invalid, fpu_flag_divbyzero, fpu_flag_overflow,
                           fpu_flag_underflow, fpu_flag_inexact};
          rsp_illegal_d = 1'b0;
          state_d       = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A clear coinciding with a handshake keeps only the completing op's flags.
    if (fflags_clr && handshake) fflags_d = rsp_fflags_q;
    else if (fflags_clr)         fflags_d = 5'b0;
    else if (handshake)          fflags_d = fflags_q | rsp_fflags_q;
  end

  // NOTE: sequential state uses non-blocking assignments only; every register, datapath included, is reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= 4'b0;
      fpu_func7_q   <= 7'b0;
      fpu_func3_q   <= 3'b0;
      fpu_rs2_q     <= 5'b0;
      fpu_a_q       <= 64'b0;
      fpu_b_q       <= 64'b0;
      rsp_rd_q      <= 5'b0;
      rsp_data_q    <= 64'b0;
      rsp_fflags_q  <= 5'b0;
      rsp_illegal_q <= 1'b0;
      fflags_q      <= 5'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      fpu_func7_q   <= fpu_func7_d;
      fpu_func3_q   <= fpu_func3_d;
      fpu_rs2_q     <= fpu_rs2_d;
      fpu_a_q       <= fpu_a_d;
      fpu_b_q       <= fpu_b_d;
      rsp_rd_q      <= rsp_rd_d;
      rsp_data_q    <= rsp_data_d;
      rsp_fflags_q  <= rsp_fflags_d;
      rsp_illegal_q <= rsp_illegal_d;
      fflags_q      <= fflags_d;
    end
  end

  assign req_ready     = (state_q == IDLE);
  assign rsp_valid     = (state_q == RESP);
  assign busy          = (state_q != IDLE);
  assign fpu_func7     = fpu_func7_q;
  assign fpu_func3     = fpu_func3_q;
  assign fpu_rs2       = fpu_rs2_q;
  assign fpu_operand_a = fpu_a_q;
  assign fpu_operand_b = fpu_b_q;
  assign rsp_rd        = rsp_rd_q;
  assign rsp_data      = rsp_data_q;
  assign rsp_fflags    = rsp_fflags_q;
  assign rsp_illegal   = rsp_illegal_q;
  assign fflags        = fflags_q;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Bench for fpu_issue_ctrl: transaction-level reference model compared every cycle, directed
// scenarios with literal expectations, then randomized traffic.
module tb_fpu_issue_ctrl;

  localparam int L = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_valid = 1'b0;
  logic [6:0]  req_func7 = '0;
  logic [2:0]  req_func3 = '0;
  logic [4:0]  req_rs2 = '0;
  logic [4:0]  req_rd = '0;
  logic [63:0] req_a = '0;
  logic [63:0] req_b = '0;
  logic [2:0]  fcsr_frm = '0;
  logic [63:0] fpu_result = '0;
  logic [4:0]  fl = '0;
  logic        fcmp = 1'b0;
  logic        rsp_ready = 1'b0;
  logic        fflags_clr = 1'b0;

  logic        req_ready, rsp_valid, rsp_illegal, busy;
  logic [6:0]  fpu_func7;
  logic [2:0]  fpu_func3;
  logic [4:0]  fpu_rs2, rsp_rd, rsp_fflags, fflags;
  logic [63:0] fpu_operand_a, fpu_operand_b, rsp_data;

  always #5 clk = ~clk;

  fpu_issue_ctrl #(.RESULT_LAT(L)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_func7(req_func7), .req_func3(req_func3), .req_rs2(req_rs2), .req_rd(req_rd),
    .req_a(req_a), .req_b(req_b), .fcsr_frm(fcsr_frm),
    .fpu_func7(fpu_func7), .fpu_func3(fpu_func3), .fpu_rs2(fpu_rs2),
    .fpu_operand_a(fpu_operand_a), .fpu_operand_b(fpu_operand_b),
    .fpu_result(fpu_result),
    .fpu_flag_invalid(fl[4]), .fpu_flag_divbyzero(fl[3]), .fpu_flag_overflow(fl[2]),
    .fpu_flag_underflow(fl[1]), .fpu_flag_inexact(fl[0]), .fpu_flag_cmp(fcmp),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rd(rsp_rd), .rsp_data(rsp_data),
    .rsp_fflags(rsp_fflags), .rsp_illegal(rsp_illegal),
    .fflags(fflags), .fflags_clr(fflags_clr), .busy(busy)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: one outstanding op, response available from edge m_cap onwards.
  int          edge_no = 0;
  bit          m_busy = 0;
  bit          m_legal = 0;
  int          m_cap = 0;
  logic [6:0]  m_op = '0;
  logic [4:0]  m_ff = '0;
  logic [6:0]  e_f7 = '0;
  logic [2:0]  e_f3 = '0;
  logic [4:0]  e_rs2 = '0;
  logic [63:0] e_a = '0, e_b = '0;
  logic [4:0]  e_rd = '0, e_ff = '0;
  logic [63:0] e_data = '0;
  logic        e_ill = 1'b0;

  logic [6:0] legal_ops [12] = '{7'h00, 7'h04, 7'h01, 7'h05, 7'h50, 7'h51,
                                 7'h21, 7'h60, 7'h69, 7'h20, 7'h61, 7'h68};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit model_rsp_valid();
    return m_busy && (edge_no >= m_cap);
  endfunction

  task automatic model_reset();
    m_busy = 0; m_legal = 0; m_ff = '0;
    e_f7 = '0; e_f3 = '0; e_rs2 = '0; e_a = '0; e_b = '0;
    e_rd = '0; e_ff = '0; e_data = '0; e_ill = 1'b0;
  endtask

  task automatic update_model();
    bit vpre, hs, cmp, legal;
    logic [2:0] rm;
    vpre = model_rsp_valid();
    edge_no++;
    hs = vpre && rsp_ready;
    if (fflags_clr && hs)  m_ff = e_ff;
    else if (fflags_clr)   m_ff = 5'b0;
    else if (hs)           m_ff = m_ff | e_ff;
    if (hs) begin
      m_busy = 0;
    end else if (!m_busy && req_valid) begin
      cmp   = (req_func7 == 7'h50) || (req_func7 == 7'h51);
      rm    = cmp ? req_func3 : ((req_func3 == 3'b111) ? fcsr_frm : req_func3);
      legal = (req_func7 inside {legal_ops}) && (cmp || !(rm inside {3'd5, 3'd6, 3'd7}));
      m_busy = 1; m_legal = legal; m_op = req_func7; e_rd = req_rd;
      if (legal) begin
        e_f7 = req_func7; e_f3 = rm; e_rs2 = req_rs2; e_a = req_a; e_b = req_b;
        m_cap = edge_no + L;
      end else begin
        m_cap = edge_no; e_ill = 1'b1; e_data = '0; e_ff = '0;
      end
    end else if (m_busy && m_legal && edge_no == m_cap) begin
      if (m_op == 7'h50 || m_op == 7'h51) begin
        e_data = {63'b0, fcmp};
      end else begin
        e_data = fpu_result;
`ifdef FPU_NANBOX_EN
        if (m_op inside {7'h00, 7'h04, 7'h20, 7'h68}) e_data[63:32] = 32'hFFFF_FFFF;
`endif
      end
      e_ff = fl; e_ill = 1'b0;
    end
  endtask

  task automatic compare();
    bit ev;
    ev = model_rsp_valid();
    check("req_ready", req_ready, !m_busy);
    check("busy", busy, m_busy);
    check("rsp_valid", rsp_valid, ev);
    check("fflags", fflags, m_ff);
    check("fpu_func7", fpu_func7, e_f7);
    check("fpu_func3", fpu_func3, e_f3);
    check("fpu_rs2", fpu_rs2, e_rs2);
    check("fpu_operand_a", fpu_operand_a, e_a);
    check("fpu_operand_b", fpu_operand_b, e_b);
    if (ev) begin
      check("rsp_illegal", rsp_illegal, e_ill);
      check("rsp_data", rsp_data, e_data);
      check("rsp_fflags", rsp_fflags, e_ff);
      if (!e_ill) check("rsp_rd", rsp_rd, e_rd);
    end
  endtask

  // Called just after a falling edge with inputs already set; returns after the next falling edge.
  task automatic cycle();
    compare();
    @(posedge clk);
    update_model();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_fflags", fflags, 5'b0);
    check("rst_rsp_data", rsp_data, 64'b0);
    check("rst_rsp_fflags", rsp_fflags, 5'b0);
    check("rst_rsp_illegal", rsp_illegal, 1'b0);
    check("rst_rsp_rd", rsp_rd, 5'b0);
    check("rst_fpu_func7", fpu_func7, 7'b0);
    check("rst_fpu_func3", fpu_func3, 3'b0);
    check("rst_fpu_rs2", fpu_rs2, 5'b0);
    check("rst_fpu_a", fpu_operand_a, 64'b0);
    check("rst_fpu_b", fpu_operand_b, 64'b0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic set_req(input logic [6:0] f7, input logic [2:0] f3, input logic [4:0] rd,
                         input logic [63:0] a, input logic [63:0] b);
    req_func7 = f7; req_func3 = f3; req_rs2 = 5'd3; req_rd = rd; req_a = a; req_b = b;
  endtask

  task automatic issue(input logic [6:0] f7, input logic [2:0] f3, input logic [4:0] rd,
                       input logic [63:0] a, input logic [63:0] b);
    set_req(f7, f3, rd, a, b);
    req_valid = 1'b1;
    cycle();
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string name);
    int n = 0;
    while (!model_rsp_valid() && n < 40) begin
      cycle();
      n++;
    end
    if (n >= 40) begin
      vectors++;
      miscompares++;
      $display("FAIL %s: no response within 40 cycles", name);
    end
  endtask

  task automatic finish_rsp();
    rsp_ready = 1'b1;
    cycle();
    rsp_ready = 1'b0;
  endtask

  initial begin
    #2;
    apply_reset();

    // FADD_S, static rounding
    fpu_result = 64'h0000_0000_4040_0000; fl = 5'b0; fcmp = 1'b0;
    issue(7'h00, 3'b000, 5'd5, 64'h3F80_0000, 64'h4000_0000);
    check("fadd_s_cmd_a", fpu_operand_a, 64'h3F80_0000);
    repeat (L - 1) cycle();
    check("fadd_s_not_yet", rsp_valid, 1'b0);
    cycle();
    check("fadd_s_valid", rsp_valid, 1'b1);
`ifdef FPU_NANBOX_EN
    check("fadd_s_data", rsp_data, 64'hFFFF_FFFF_4040_0000);
`else
    check("fadd_s_data", rsp_data, 64'h0000_0000_4040_0000);
`endif
    check("fadd_s_rd", rsp_rd, 5'd5);
    finish_rsp();

    // FADD_D, dynamic rounding legal then illegal
    fcsr_frm = 3'b010; fpu_result = 64'h4008_0000_0000_0000;
    issue(7'h01, 3'b111, 5'd6, 64'h3FF0_0000_0000_0000, 64'h4000_0000_0000_0000);
    check("fadd_d_dyn_func3", fpu_func3, 3'b010);
    wait_rsp("fadd_d_dyn");
    finish_rsp();
    fcsr_frm = 3'b101;
    issue(7'h01, 3'b111, 5'd7, 64'h1234, 64'h5678);
    check("fadd_d_bad_valid", rsp_valid, 1'b1);
    check("fadd_d_bad_illegal", rsp_illegal, 1'b1);
    check("fadd_d_bad_func3_held", fpu_func3, 3'b010);
    check("fadd_d_bad_a_held", fpu_operand_a, 64'h3FF0_0000_0000_0000);
    finish_rsp();

    // FCMP_S ignores an out-of-range fcsr_frm
    fcsr_frm = 3'b110; fcmp = 1'b1; fl = 5'b0; fpu_result = 64'hDEAD_BEEF;
    issue(7'h50, 3'b010, 5'd8, 64'h1, 64'h2);
    check("fcmp_func3", fpu_func3, 3'b010);
    wait_rsp("fcmp");
    check("fcmp_data", rsp_data, 64'h1);
    check("fcmp_fflags", rsp_fflags, 5'b0);
    check("fcmp_illegal", rsp_illegal, 1'b0);
    finish_rsp();
    fcmp = 1'b0; fcsr_frm = 3'b000;

    // Sticky flags
    fflags_clr = 1'b1; cycle(); fflags_clr = 1'b0;
    check("sticky_cleared", fflags, 5'b0);
    fl = 5'b00001; issue(7'h05, 3'b000, 5'd1, 64'h11, 64'h22); wait_rsp("sticky1"); finish_rsp();
    check("sticky_op1", fflags, 5'b00001);
    fl = 5'b00101; issue(7'h21, 3'b001, 5'd2, 64'h33, 64'h44); wait_rsp("sticky2"); finish_rsp();
    check("sticky_op2", fflags, 5'b00101);
    fl = 5'b10000; issue(7'h60, 3'b000, 5'd3, 64'h55, 64'h66); wait_rsp("sticky3");
    rsp_ready = 1'b1; fflags_clr = 1'b1; cycle(); rsp_ready = 1'b0; fflags_clr = 1'b0;
    check("sticky_clr_hs", fflags, 5'b10000);

    // Unsupported opcode leaves fflags alone
    fl = 5'b01010;
    issue(7'h08, 3'b000, 5'd9, 64'h77, 64'h88);
    check("bad_op_illegal", rsp_illegal, 1'b1);
    check("bad_op_data", rsp_data, 64'b0);
    check("bad_op_fflags", rsp_fflags, 5'b0);
    finish_rsp();
    check("bad_op_sticky", fflags, 5'b10000);

    // Backpressure with a second request waiting
    fl = 5'b00010;
    issue(7'h05, 3'b001, 5'd10, 64'h99, 64'hAA); wait_rsp("bp_first");
    set_req(7'h61, 3'b000, 5'd11, 64'hBB, 64'hCC);
    req_valid = 1'b1;
    repeat (5) begin
      cycle();
      check("bp_req_ready", req_ready, 1'b0);
    end
    check("bp_sticky", fflags, 5'b10000);
    rsp_ready = 1'b1; cycle(); rsp_ready = 1'b0;
    check("bp_ready_after_hs", req_ready, 1'b1);
    cycle();
    req_valid = 1'b0;
    check("bp_second_busy", busy, 1'b1);
    check("bp_second_cmd", fpu_func7, 7'h61);
    wait_rsp("bp_second"); finish_rsp();

    // Reset while executing
    issue(7'h69, 3'b000, 5'd12, 64'hEE, 64'hFF);
    cycle();
    apply_reset();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      req_valid = ($urandom_range(0, 99) < 60);
      req_func7 = ($urandom_range(0, 9) == 0) ? 7'($urandom) : legal_ops[$urandom_range(0, 11)];
      req_func3 = 3'($urandom);
      req_rs2   = 5'($urandom);
      req_rd    = 5'($urandom);
      req_a     = {$urandom, $urandom};
      req_b     = {$urandom, $urandom};
      fcsr_frm  = 3'($urandom);
      fpu_result = {$urandom, $urandom};
      fl        = 5'($urandom);
      fcmp      = 1'($urandom);
      rsp_ready = ($urandom_range(0, 99) < 50);
      fflags_clr = ($urandom_range(0, 99) < 8);
      cycle();
    end
    req_valid = 1'b0; rsp_ready = 1'b0; fflags_clr = 1'b0;
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
